// File: rtl/reg_file_scoreboard.sv
// Parametrised register file: one write port, two registered read ports
// with write bypass, port-B immediate, and a pending-write hazard scoreboard.
module reg_file_scoreboard #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter bit ZERO_REG   = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] read_addr_a,
   input  logic [ADDR_WIDTH-1:0] read_addr_b,
   input  logic                  immediate,
   input  logic [DATA_WIDTH-1:0] imm_value,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  pend_set,
   input  logic [ADDR_WIDTH-1:0] pend_addr,
   output logic [DATA_WIDTH-1:0] read_data_a,
   output logic [DATA_WIDTH-1:0] read_data_b,
   output logic                  hazard
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_pend;
   logic [DATA_WIDTH-1:0] r_rd_a;
   logic [DATA_WIDTH-1:0] r_rd_b;
   logic                  r_hazard;

   logic                  w_zb_w;
   logic                  w_zb_p;
   logic                  w_zb_a;
   logic                  w_zb_b;
   logic                  w_wr_ok;
   logic                  w_ps_ok;
   logic                  w_byp_a;
   logic                  w_byp_b;
   logic                  w_hit_a;
   logic                  w_hit_b;
   logic                  w_haz;
   logic [DATA_WIDTH-1:0] w_dat_a;
   logic [DATA_WIDTH-1:0] w_dat_b;
   logic [DEPTH-1:0]      w_clr;
   logic [DEPTH-1:0]      w_set;

   always_comb begin
      w_zb_w  = ZERO_REG && (write_addr == '0);
      w_zb_p  = ZERO_REG && (pend_addr == '0);
      w_zb_a  = ZERO_REG && (read_addr_a == '0);
      w_zb_b  = ZERO_REG && (read_addr_b == '0);
      w_wr_ok = write_enable && !w_zb_w;
      w_ps_ok = pend_set && !w_zb_p;
      w_byp_a = write_enable && (write_addr == read_addr_a);
      w_byp_b = write_enable && (write_addr == read_addr_b);
      w_dat_a = w_zb_a  ? '0
              : w_byp_a ? write_data
              : r_regs[read_addr_a];
      w_dat_b = immediate ? imm_value
              : w_zb_b    ? '0
              : w_byp_b   ? write_data
              : r_regs[read_addr_b];
      // hits use pre-edge pending; a same-cycle write retires the hazard
      w_hit_a = r_pend[read_addr_a] && !w_byp_a;
      w_hit_b = r_pend[read_addr_b] && !w_byp_b;
      w_haz   = w_hit_a || (!immediate && w_hit_b);
      w_clr   = w_wr_ok ? (ONE << write_addr) : '0;
      w_set   = w_ps_ok ? (ONE << pend_addr) : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[write_addr] <= write_data;
      end
   end

   // set is applied after clear so a same-cycle set wins
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_a   <= '0;
         r_rd_b   <= '0;
         r_hazard <= 1'b0;
      end else if (!stall) begin
         r_rd_a   <= w_dat_a;
         r_rd_b   <= w_dat_b;
         r_hazard <= w_haz;
      end
   end

   assign read_data_a = r_rd_a;
   assign read_data_b = r_rd_b;
   assign hazard      = r_hazard;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: two instances (ZERO_REG=0/1) against
// an array-based reference model, directed plan then random traffic.
module tb_reg_file_scoreboard;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       stall;
   logic [2:0] read_addr_a;
   logic [2:0] read_addr_b;
   logic       immediate;
   logic [7:0] imm_value;
   logic       write_enable;
   logic [2:0] write_addr;
   logic [7:0] write_data;
   logic       pend_set;
   logic [2:0] pend_addr;

   logic [7:0] a0, b0, a1, b1;
   logic       h0, h1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_regs [2][8];
   bit         m_pend [2][8];
   logic [7:0] m_a [2];
   logic [7:0] m_b [2];
   logic       m_h [2];

   always #5 clock = ~clock;

   reg_file_scoreboard #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) u0 (
      .clock(clock), .reset_n(reset_n), .stall(stall),
      .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
      .immediate(immediate), .imm_value(imm_value),
      .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .pend_set(pend_set), .pend_addr(pend_addr),
      .read_data_a(a0), .read_data_b(b0), .hazard(h0)
   );

   reg_file_scoreboard #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) u1 (
      .clock(clock), .reset_n(reset_n), .stall(stall),
      .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
      .immediate(immediate), .imm_value(imm_value),
      .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .pend_set(pend_set), .pend_addr(pend_addr),
      .read_data_a(a1), .read_data_b(b1), .hazard(h1)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 8; i++) begin
            m_regs[z][i] = 8'h00;
            m_pend[z][i] = 1'b0;
         end
         m_a[z] = 8'h00;
         m_b[z] = 8'h00;
         m_h[z] = 1'b0;
      end
   endtask

   function automatic logic [7:0] rd(input int z, input logic [2:0] ad);
      if (z == 1 && ad == 3'd0) return 8'h00;
      if (write_enable && write_addr == ad) return write_data;
      return m_regs[z][ad];
   endfunction

   function automatic logic hit(input int z, input logic [2:0] ad);
      return m_pend[z][ad] && !(write_enable && write_addr == ad);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_a0"}, a0, m_a[0]);
      chk({tag, "_b0"}, b0, m_b[0]);
      chk({tag, "_h0"}, {7'd0, h0}, {7'd0, m_h[0]});
      chk({tag, "_a1"}, a1, m_a[1]);
      chk({tag, "_b1"}, b1, m_b[1]);
      chk({tag, "_h1"}, {7'd0, h1}, {7'd0, m_h[1]});
   endtask

   // one clock: model advances with the inputs present at the edge
   task automatic tick(input string tag);
      @(posedge clock);
      #1;
      if (!reset_n) begin
         model_reset();
      end else begin
         for (int z = 0; z < 2; z++) begin
            if (!stall) begin
               m_a[z] = rd(z, read_addr_a);
               m_b[z] = immediate ? imm_value : rd(z, read_addr_b);
               m_h[z] = hit(z, read_addr_a) ||
                        (!immediate && hit(z, read_addr_b));
            end
            if (write_enable && !(z == 1 && write_addr == 3'd0)) begin
               m_regs[z][write_addr] = write_data;
               m_pend[z][write_addr] = 1'b0;
            end
            if (pend_set && !(z == 1 && pend_addr == 3'd0))
               m_pend[z][pend_addr] = 1'b1;
         end
      end
      check_all(tag);
   endtask

   task automatic idle();
      stall        = 1'b0;
      read_addr_a  = 3'd0;
      read_addr_b  = 3'd0;
      immediate    = 1'b0;
      imm_value    = 8'h00;
      write_enable = 1'b0;
      write_addr   = 3'd0;
      write_data   = 8'h00;
      pend_set     = 1'b0;
      pend_addr    = 3'd0;
   endtask

   initial begin
      model_reset();
      idle();
      reset_n = 1'b0;
      tick("rst1");
      tick("rst2");
      chk("rst_a", a0, 8'h00);
      chk("rst_h", {7'd0, h0}, 8'h00);
      reset_n = 1'b1;

      write_enable = 1'b1; write_addr = 3'd3; write_data = 8'h5A;
      tick("wr3");
      idle(); read_addr_a = 3'd3; read_addr_b = 3'd3;
      tick("rd3");
      chk("basic_a", a0, 8'h5A);
      chk("basic_b", b0, 8'h5A);
      chk("basic_h", {7'd0, h0}, 8'h00);

      idle(); write_enable = 1'b1; write_addr = 3'd2; write_data = 8'h11;
      tick("wr2");
      write_data = 8'hC3; read_addr_a = 3'd2;
      tick("byp");
      chk("bypass_a", a0, 8'hC3);

      idle(); immediate = 1'b1; imm_value = 8'h7F; read_addr_b = 3'd3;
      tick("imm");
      chk("imm_b", b0, 8'h7F);

      idle(); pend_set = 1'b1; pend_addr = 3'd3;
      tick("pend3");
      idle(); immediate = 1'b1; imm_value = 8'h01; read_addr_b = 3'd3;
      tick("immpend");
      chk("imm_pend_h", {7'd0, h0}, 8'h00);

      idle(); pend_set = 1'b1; pend_addr = 3'd4;
      tick("pend4");
      idle(); read_addr_a = 3'd4;
      tick("haz4");
      chk("haz4_h", {7'd0, h0}, 8'h01);
      write_enable = 1'b1; write_addr = 3'd4; write_data = 8'h99;
      tick("wr4");
      chk("wr4_h", {7'd0, h0}, 8'h00);
      chk("wr4_a", a0, 8'h99);

      idle(); pend_set = 1'b1; pend_addr = 3'd5;
      write_enable = 1'b1; write_addr = 3'd5; write_data = 8'h21;
      tick("setwin");
      idle(); read_addr_a = 3'd5; read_addr_b = 3'd5;
      tick("rd5");
      chk("setwin_h", {7'd0, h0}, 8'h01);
      chk("setwin_a", a0, 8'h21);

      idle(); read_addr_a = 3'd4; read_addr_b = 3'd2;
      tick("prestall");
      stall = 1'b1; read_addr_a = 3'd5; read_addr_b = 3'd3;
      write_enable = 1'b1; write_addr = 3'd1; write_data = 8'h44;
      tick("stall1");
      write_enable = 1'b0; read_addr_a = 3'd6; read_addr_b = 3'd5;
      tick("stall2");
      read_addr_a = 3'd3; read_addr_b = 3'd4;
      tick("stall3");
      chk("stall_a", a0, 8'h99);
      chk("stall_b", b0, 8'hC3);
      chk("stall_h", {7'd0, h0}, 8'h00);
      idle(); read_addr_a = 3'd1;
      tick("rd1");
      chk("stall_wr_a", a0, 8'h44);

      idle(); write_enable = 1'b1; write_addr = 3'd0; write_data = 8'hFF;
      tick("wr0");
      idle(); read_addr_a = 3'd0; pend_set = 1'b1; pend_addr = 3'd0;
      tick("rd0");
      chk("zero_a1", a1, 8'h00);
      chk("zero_a0", a0, 8'hFF);
      idle(); read_addr_a = 3'd0;
      tick("haz0");
      chk("zero_h1", {7'd0, h1}, 8'h00);
      chk("zero_h0", {7'd0, h0}, 8'h01);

      idle(); write_enable = 1'b1; write_addr = 3'd6; write_data = 8'h12;
      pend_set = 1'b1; pend_addr = 3'd6;
      tick("wr6");
      idle(); read_addr_a = 3'd6; read_addr_b = 3'd6;
      tick("rd6");
      chk("pre_rst_a", a0, 8'h12);
      chk("pre_rst_h", {7'd0, h0}, 8'h01);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async");
      chk("async_a", a0, 8'h00);
      chk("async_h", {7'd0, h0}, 8'h00);
      tick("inrst");
      reset_n = 1'b1;
      tick("postrst");
      chk("post_a", a0, 8'h00);
      chk("post_h", {7'd0, h0}, 8'h00);

      for (int n = 0; n < 400; n++) begin
         stall        = ($urandom_range(0, 3) == 0);
         read_addr_a  = 3'($urandom_range(0, 7));
         read_addr_b  = 3'($urandom_range(0, 7));
         immediate    = ($urandom_range(0, 3) == 0);
         imm_value    = 8'($urandom);
         write_enable = ($urandom_range(0, 1) == 1);
         write_addr   = 3'($urandom_range(0, 7));
         write_data   = 8'($urandom);
         pend_set     = ($urandom_range(0, 2) == 0);
         pend_addr    = 3'($urandom_range(0, 7));
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised successor of the core's 8x8 register file. It provides one write port and two registered read ports, with same-cycle write-to-read bypass and an immediate override on port B. A per-register pending-write scoreboard flags read-after-write hazards for the control unit. It sits between decode and the ALU: decode drives the read and pending-set fields, and writeback drives the write port.

Parameters:
DATA_WIDTH, 8, width of each register and of all data ports
ADDR_WIDTH, 3, register address width; depth = 2**ADDR_WIDTH
ZERO_REG, 0, when 1, register 0 always reads as zero and ignores writes and pend_set

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
stall  input  1  1 = hold read_data_a, read_data_b and hazard
read_addr_a  input  ADDR_WIDTH  port A read address
read_addr_b  input  ADDR_WIDTH  port B read address
immediate  input  1  1 = port B returns imm_value instead of a register
imm_value  input  DATA_WIDTH  immediate operand for port B
write_enable  input  1  commit write_data to write_addr
write_addr  input  ADDR_WIDTH  write address
write_data  input  DATA_WIDTH  write data
pend_set  input  1  mark pend_addr as having a result in flight
pend_addr  input  ADDR_WIDTH  register to mark pending
read_data_a  output  DATA_WIDTH  registered port A data
read_data_b  output  DATA_WIDTH  registered port B data
hazard  output  1  registered; a sampled source register was pending

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-operation):
  - all registers = 0
  - all pending bits = 0
  - read_data_a = 0, read_data_b = 0, hazard = 0
- Reset release: first active edge is the first rising clock edge with reset_n high.
- Write:
  - At posedge, if write_enable: regs[write_addr] <= write_data and pending[write_addr] <= 0.
  - If ZERO_REG=1 and write_addr=0: no effect.
- Pending set:
  - At posedge, if pend_set: pending[pend_addr] <= 1.
  - If pend_set and write_enable target the same address in the same cycle: set wins, pending = 1 and the data is written.
  - If ZERO_REG=1 and pend_addr=0: ignored.
- Reads:
  - Latency is 1 cycle: addresses sampled at edge N appear on the outputs after edge N.
  - Port A, when stall=0: read_data_a <= (write_enable && write_addr==read_addr_a && !zero_blocked) ? write_data : regs[read_addr_a].
  - zero_blocked = (ZERO_REG && address==0). A zero_blocked read returns 0.
  - Port B, when stall=0: read_data_b <= immediate ? imm_value : same rule as port A using read_addr_b.
  - Reads of an address being written in the same cycle always return the new data (bypass); they never return stale data.
- Hazard:
  - When stall=0: hazard <= hitA || (!immediate && hitB).
  - hitX = pending[read_addr_X] && !(write_enable && write_addr==read_addr_X), evaluated on pre-edge pending state.
  - pend_set in the same cycle does not affect that cycle's hazard.
- Stall:
  - read_data_a, read_data_b and hazard hold their values.
  - Writes and pending updates still occur.
- Address width: out-of-range addresses do not exist, since depth is exactly 2**ADDR_WIDTH.
- No combinational path from any input to any output.

Test Plan:
- Reset and basic read: hold reset_n=0 for 2 cycles, release; write 0x5A to r3, then read A=r3, B=r3 next cycle -> read_data_a=read_data_b=0x5A one cycle after the read edge; hazard=0.
- Bypass: in the same cycle write_enable=1, write_addr=2, write_data=0xC3, read_addr_a=2 (r2 previously 0x11) -> read_data_a=0xC3 after that edge.
- Immediate: immediate=1, imm_value=0x7F, read_addr_b=3 (r3=0x5A) -> read_data_b=0x7F.
- Immediate with pending: with r3 pending, immediate=1, read_addr_b=3 -> hazard=0.
- Scoreboard:
  - pend_set r4 -> next cycle read_addr_a=4 -> hazard=1.
  - Write r4=0x99 while reading r4 -> hazard=0 and read_data_a=0x99.
  - pend_set and write to r5 in the same cycle -> a later read of r5 gives hazard=1.
- Stall and zero register: stall=1 for 3 cycles while read addresses change -> outputs frozen. A write to r1 during the stall is visible on a later read of r1 (0x44). With ZERO_REG=1, a write of 0xFF to r0 -> a read of r0 returns 0x00 and pend_set r0 -> hazard=0.
- Async reset mid-operation: assert reset_n=0 between clock edges with r6=0x12 pending -> outputs and hazard drop to 0 immediately; a post-reset read of r6 returns 0x00 with hazard=0.
